md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have ports: start  in  1  E-stage MD operation valid this cycle.
REQ-004 SHALL have ports: op  in  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-005 SHALL have ports: D1  in  32  rs operand (E-stage, post-forwarding).
REQ-006 SHALL have ports: D2  in  32  rt operand (E-stage, post-forwarding).
REQ-007 SHALL have ports: flush  in  1  exception/interrupt taken; cancels E-stage start this cycle.
REQ-008 SHALL have ports: md_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have ports: busy  out  1  multi-cycle operation in progress.
REQ-010 SHALL have ports: stall_md  out  1  stall request to pipeline hazard control.
REQ-011 SHALL have ports: HI  out  32  HI register.
REQ-012 SHALL have ports: LO  out  32  LO register.
REQ-013 Parameters: MULT_LAT, default 5, busy cycles for mult/multu; DIV_LAT, default 10, busy cycles for div/divu.

Function
REQ-014 FSM states: IDLE, RUN; 4-bit down-counter cnt; internal result registers res_hi, res_lo.
REQ-015 Accepted start = start & ~flush & (state==IDLE).
REQ-016 Accepted start with op 0-3: compute result into res_hi/res_lo at that edge, load cnt with MULT_LAT or DIV_LAT, go RUN.
REQ-017 RUN: cnt decrements each edge; at edge where cnt==1, HI<=res_hi, LO<=res_lo, state<=IDLE.
REQ-018 busy = (state==RUN), registered; high exactly LAT cycles, starting the cycle after the start edge.
REQ-019 HI/LO SHALL not change while busy; new values visible the cycle busy falls.
REQ-020 stall_md = md_D & (busy | (start & ~flush & op<=3)), combinational.
REQ-021 mult: {HI,LO} = signed D1 * signed D2, 64-bit; multu: unsigned 64-bit product.
REQ-022 div: LO = signed quotient truncated toward zero, HI = remainder with sign of D1; divu: unsigned quotient/remainder.
REQ-023 div with D1=0x80000000, D2=0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-024 div/divu with D2==0: busy sequence runs normally; HI and LO retain prior values at completion.
REQ-025 mthi/mtlo accepted: HI<=D1 (mthi) or LO<=D1 (mtlo) at that edge; no busy, no stall.
REQ-026 start while RUN (any op): ignored; running operation unaffected.
REQ-027 flush while RUN: no effect on running operation; only gates start in same cycle.
REQ-028 op 6-7 with start: no state change.

Reset
REQ-029 reset low: immediately state=IDLE, cnt=0, busy=0, HI=0, LO=0, res_hi=res_lo=0, independent of clk.
REQ-030 reset low mid-operation: operation aborted; HI/LO=0; after release, next start accepted normally.
REQ-031 stall_md while reset low: follows REQ-020 with busy=0.

Verification
REQ-032 mult D1=0xFFFFFFFE, D2=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu D1=0xFFFFFFFF, D2=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 div D1=-7 (0xFFFFFFF9), D2=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu D2=0 -> HI/LO unchanged.
REQ-035 start=1, flush=1, op=mult -> busy stays 0, HI/LO unchanged, stall_md=0 with md_D=1.
REQ-036 md_D=1 during all busy cycles -> stall_md=1 each cycle, 0 the cycle busy falls; mtlo D1=0x1234 while busy -> ignored.
REQ-037 reset driven low at RUN cycle 3 of div -> busy=0, HI=LO=0 without clock edge; post-release mult completes in 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: mult/div results land in HI/LO after MULT_LAT/DIV_LAT busy cycles, mthi/mtlo write immediately.
// No backpressure: starts while busy are dropped; stall_md holds the D-stage MD instruction until the unit is idle.
module md_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        flush,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        wr_q, wr_d;

    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_abs, b_abs, dvd, dvs, quo, rem;
    logic [31:0] quo_s, rem_s;

    // Both products come from 64-bit multiplies; the signed one uses sign-extended operands.
    assign prod_u = {32'd0, D1} * {32'd0, D2};
    assign prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};

    // Signed division runs on magnitudes with signs restored afterwards; 0x80000000/-1 wraps to 0x80000000 rem 0.
    assign a_abs = D1[31] ? (32'd0 - D1) : D1;
    assign b_abs = D2[31] ? (32'd0 - D2) : D2;
    assign dvd   = (op == 3'd2) ? a_abs : D1;
    assign dvs   = (D2 == 32'd0) ? 32'd1 : ((op == 3'd2) ? b_abs : D2);
    assign quo   = dvd / dvs;
    assign rem   = dvd % dvs;
    assign quo_s = (D1[31] ^ D2[31]) ? (32'd0 - quo) : quo;
    assign rem_s = D1[31] ? (32'd0 - rem) : rem;

    assign accept = start & ~flush & (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        3'd0: begin
                            {res_hi_d, res_lo_d} = prod_s;
                            cnt_d   = 4'(MULT_LAT);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
                        3'd1: begin
                            {res_hi_d, res_lo_d} = prod_u;
                            cnt_d   = 4'(MULT_LAT);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
                        3'd2: begin
                            res_hi_d = rem_s;
                            res_lo_d = quo_s;
                            cnt_d    = 4'(DIV_LAT);
                            wr_d     = (D2 != 32'd0);
                            state_d  = RUN;
                        end
                        3'd3: begin
                            res_hi_d = rem;
                            res_lo_d = quo;
                            cnt_d    = 4'(DIV_LAT);
                            wr_d     = (D2 != 32'd0);
                            state_d  = RUN;
                        end
                        3'd4:    hi_d = D1;
                        3'd5:    lo_d = D1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    // Divide by zero completes the busy sequence but leaves HI/LO untouched.
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wr_q     <= wr_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign stall_md = md_D & (busy | (start & ~flush & ~op[2]));
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO results are queued at issue and checked when busy falls.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] D1, D2;
    logic        flush;
    logic        md_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI, LO;

    md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .D1(D1), .D2(D2),
        .flush(flush), .md_D(md_D), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles, watches HI/LO stay frozen while busy, and scores each completion.
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    logic [63:0] held;
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                if (busy_cnt == 0) held = {HI, LO};
                else chk("hilo_frozen_while_busy", {HI, LO}, held);
                busy_cnt++;
            end else if (prev_busy) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got HI=%h LO=%h expected no result", HI, LO);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("busy_length", 64'(busy_cnt), 64'(e.lat));
                    chk("result_hi", {32'd0, HI}, {32'd0, e.hi});
                    chk("result_lo", {32'd0, LO}, {32'd0, e.lo});
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Called at posedge+1; the op is sampled at the next posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
        start = 1'b1; op = o; D1 = a; D2 = b; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 3'd7;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (md_D) chk({name, "_stall_busy"}, {63'd0, stall_md}, 64'd1);
            n++;
            if (n >= 40) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got busy=1 after %0d cycles expected busy=0", name, n);
                break;
            end
        end
        if (md_D) chk({name, "_stall_release"}, {63'd0, stall_md}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.lat = lat; e.hi = eh; e.lo = el;
        sbq.push_back(e);
        md_D = 1'b1;
        start = 1'b1; op = o; D1 = a; D2 = b; flush = 1'b0;
        #1 chk({name, "_stall_start"}, {63'd0, stall_md}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
        chk({name, "_busy_rise"}, {63'd0, busy}, 64'd1);
        wait_idle(name);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd7; D1 = '0; D2 = '0; flush = 1'b0; md_D = 1'b0;
        #2 reset = 1'b0;
        start = 1'b1; op = 3'd0; md_D = 1'b1;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        chk("reset_stall", {63'd0, stall_md}, 64'd1);
        start = 1'b0; md_D = 1'b0;
        #19 reset = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd55, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Flushed start must be dropped entirely.
        md_D = 1'b1;
        start = 1'b1; op = 3'd0; D1 = 32'd9; D2 = 32'd9; flush = 1'b1;
        #1 chk("flush_stall", {63'd0, stall_md}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 3'd7;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("flush_hilo", {HI, LO}, {32'd2, 32'd14});

        start = 1'b1; op = 3'd4; D1 = 32'hAAAA_5555;
        #1 chk("mthi_stall", {63'd0, stall_md}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
        chk("mthi_hi", {32'd0, HI}, {32'd0, 32'hAAAA_5555});
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        chk("mtlo_lo", {HI, LO}, {32'hAAAA_5555, 32'h1234_5678});

        // Starts issued while running are ignored and must not restart the count.
        begin
            exp_t e;
            e.lat = 5; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB;
            sbq.push_back(e);
        end
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        issue(3'd5, 32'h0000_1234, 32'd0, 1'b0);
        chk("mtlo_ignored_busy", {HI, LO}, {32'hAAAA_5555, 32'h1234_5678});
        issue(3'd1, 32'd2, 32'd2, 1'b1);
        issue(3'd1, 32'd2, 32'd2, 1'b0);
        wait_idle("mult_ignore");

        issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        chk("nop_busy", {63'd0, busy}, 64'd0);
        chk("nop_hilo", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

        // Reset in the middle of a divide aborts it without a clock edge.
        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        run_op("mult_after_reset", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
